// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg
// Shared definitions for the 0110 sync-pattern serial transmitter.
//   state_t      : FSM state encoding, also driven onto the cs debug port
//   DEF_PAT_W    : default sync pattern width
//   DEF_PATTERN  : default sync pattern (sent MSB first)
//   DEF_DATA_W   : default payload width
//   DEF_GAP      : default number of idle-high bits after a frame
//   max2()       : helper used to size the bit counter
package moore_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam int                   DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0110;
    localparam int                   DEF_DATA_W  = 8;
    localparam int                   DEF_GAP     = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/moore_seq_piso.sv
// moore_seq_piso
// Parallel-load, MSB-first shift register holding the frame payload.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset, clears the register
//   load  : capture din (has priority over shift)
//   shift : shift one place towards the MSB, zero filled
//   din   : parallel payload
//   msb   : current most significant bit (next payload bit to send)
module moore_seq_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/moore_seq_tx.sv
// moore_seq_tx
// Moore-style serial frame transmitter for the 0110 sync-pattern link.
// A frame is: PATTERN (MSB first), payload (MSB first), optional even
// parity bit, then GAP idle-high bits. All outputs are registered.
// Optional feature macro: PARITY_EN (inserts the PAR state after DATA).
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : frame request, honoured only while ready=1
//   data_in    : payload, captured on the accepting edge
//   ready      : high only in IDLE
//   s_out      : serial line, idles high
//   frame_done : one-cycle pulse during the last gap bit
//   cs         : current state encoding (debug)
// Handshake: a frame is accepted on a rising edge where start=1 and
// ready=1; start at any other time is ignored and never queued.
// The bit counter must be able to count GAP-1; GAP must be at least 1.
module moore_seq_tx
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               DATA_W  = DEF_DATA_W,
    parameter int               GAP     = DEF_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              s_out,
    output logic              frame_done,
    output logic [2:0]        cs
);

    localparam int CNT_W = $clog2(max2(PAT_W, DATA_W) + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    // Count value one cycle before the last gap bit; only consulted when GAP >= 2.
    localparam logic [CNT_W-1:0] GAP_PRE   = CNT_W'((GAP >= 2) ? GAP - 2 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pat_next;
    logic             piso_load;
    logic             piso_shift;
    logic             piso_msb;
`ifdef PARITY_EN
    logic             par_bit;
`endif

    // Pattern bit to present on the cycle after the current one while in SYNC.
    always_comb begin
        pat_next = 1'b1;
        for (int i = 0; i < PAT_W - 1; i++) begin
            if (cnt == CNT_W'(PAT_W - 2 - i)) begin
                pat_next = PATTERN[i];
            end
        end
    end

    // Shift whenever the register's MSB is being moved onto s_out.
    assign piso_load  = (state == ST_IDLE) && start;
    assign piso_shift = ((state == ST_SYNC) && (cnt == SYNC_LAST)) || (state == ST_DATA);

    moore_seq_piso #(
        .W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (data_in),
        .msb   (piso_msb)
    );

    // Outputs are loaded with the value belonging to the state being entered,
    // so each one is a pure function of the registered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            s_out      <= 1'b1;
            ready      <= 1'b1;
            frame_done <= 1'b0;
`ifdef PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    s_out <= 1'b1;
                    ready <= 1'b1;
                    if (start) begin
                        state <= ST_SYNC;
                        s_out <= PATTERN[PAT_W-1];
                        ready <= 1'b0;
`ifdef PARITY_EN
                        par_bit <= ^data_in;
`endif
                    end
                end

                ST_SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state <= ST_DATA;
                        cnt   <= '0;
                        s_out <= piso_msb;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        s_out <= pat_next;
                    end
                end

                ST_DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
`ifdef PARITY_EN
                        state <= ST_PAR;
                        s_out <= par_bit;
`else
                        state      <= ST_GAP;
                        s_out      <= 1'b1;
                        frame_done <= (GAP == 1);
`endif
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        s_out <= piso_msb;
                    end
                end

`ifdef PARITY_EN
                ST_PAR: begin
                    state      <= ST_GAP;
                    cnt        <= '0;
                    s_out      <= 1'b1;
                    frame_done <= (GAP == 1);
                end
`endif

                ST_GAP: begin
                    s_out <= 1'b1;
                    if (cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt        <= cnt + CNT_W'(1);
                        frame_done <= (cnt == GAP_PRE);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    s_out <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign cs = state;

endmodule

// File: tb/tb_moore_seq_tx.sv
// tb_moore_seq_tx
// Self-checking bench for moore_seq_tx. Expected per-cycle observations
// {cs, ready, frame_done, s_out} are queued when a frame is requested and
// popped one per clock, sampled 1 time unit after the rising edge.
// Honours PARITY_EN when the design is built with it.
module tb_moore_seq_tx;
    import moore_seq_pkg::*;

    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b0110;
    localparam int         DATA_W  = 8;
    localparam int         GAP     = 2;
`ifdef PARITY_EN
    localparam int         PAR_N   = 1;
`else
    localparam int         PAR_N   = 0;
`endif
    localparam int         FLEN    = PAT_W + DATA_W + PAR_N + GAP;

    typedef logic [5:0] obs_t;

    typedef struct {
        logic [7:0] data;
        int         poke_at;
        bit         scramble;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  data_in;
    logic        ready;
    logic        s_out;
    logic        frame_done;
    logic [2:0]  cs;

    obs_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          hold_len = 0;
    bit          scramble = 0;
    int          det_hits;
    int          det_first;
    int          bit_idx;
    logic [3:0]  det_hist;
    vec_t        vecs[7];

    moore_seq_tx #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .DATA_W  (DATA_W),
        .GAP     (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .ready      (ready),
        .s_out      (s_out),
        .frame_done (frame_done),
        .cs         (cs)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input logic [2:0] c, input logic r, input logic fd, input logic s);
        return {c, r, fd, s};
    endfunction

    function automatic obs_t observe();
        return {cs, ready, frame_done, s_out};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cs=%0d ready=%b done=%b s_out=%b, required cs=%0d ready=%b done=%b s_out=%b",
                     name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        for (int i = 0; i < PAT_W; i++)
            exp_q.push_back(mk(ST_SYNC, 1'b0, 1'b0, PATTERN[PAT_W-1-i]));
        for (int i = 0; i < DATA_W; i++)
            exp_q.push_back(mk(ST_DATA, 1'b0, 1'b0, d[DATA_W-1-i]));
`ifdef PARITY_EN
        exp_q.push_back(mk(ST_PAR, 1'b0, 1'b0, ^d));
`endif
        for (int i = 0; i < GAP; i++)
            exp_q.push_back(mk(ST_GAP, 1'b0, (i == GAP - 1), 1'b1));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk(ST_IDLE, 1'b1, 1'b0, 1'b1));
    endtask

    // Independent non-overlapping 0110 detector fed from s_out.
    task automatic det_reset();
        det_hits  = 0;
        det_first = -1;
        bit_idx   = 0;
        det_hist  = 4'b1111;
    endtask

    task automatic det_step();
        if ({det_hist[2:0], s_out} == PATTERN) begin
            det_hits++;
            if (det_first < 0) det_first = bit_idx;
            det_hist = 4'b1111;
        end else begin
            det_hist = {det_hist[2:0], s_out};
        end
        bit_idx++;
    endtask

    task automatic start_frame(input logic [7:0] d);
        start   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Compare up to max_n queued observations, one per clock.
    task automatic drain(input string name, input int poke_at, input int max_n);
        int k = 0;
        obs_t e;
        while (exp_q.size() > 0 && (max_n < 0 || k < max_n)) begin
            e = exp_q.pop_front();
            check(name, observe(), e);
            det_step();
            if (k == poke_at) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end else begin
                if (k >= hold_len) start = 1'b0;
                if (scramble) data_in = 8'($urandom_range(0, 255));
            end
            k++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;

        // reset asserted before any clock edge
        #1 rst = 1'b0;
        #1 check("reset_state", observe(), mk(ST_IDLE, 1'b1, 1'b0, 1'b1));
        @(posedge clk);
        #1 rst = 1'b1;
        push_idle(2);
        drain("idle_after_reset", -1, -1);

        vecs[0] = '{8'hA5, -1, 1'b0};
        vecs[1] = '{8'h3C,  1, 1'b1};
        vecs[2] = '{8'h07, -1, 1'b0};
        vecs[3] = '{8'h00, -1, 1'b1};
        vecs[4] = '{8'hFF, -1, 1'b0};
        vecs[5] = '{8'h66, -1, 1'b1};
        vecs[6] = '{8'($urandom_range(0, 255)), -1, 1'b1};

        for (int v = 0; v < 7; v++) begin
            det_reset();
            scramble = 1'b0;
            hold_len = 0;
            push_frame(vecs[v].data);
            push_idle(2 + $urandom_range(0, 2));
            start_frame(vecs[v].data);
            scramble = vecs[v].scramble;
            drain($sformatf("frame_%02h", vecs[v].data), vecs[v].poke_at, -1);
            check_int($sformatf("sync_detect_pos_%02h", vecs[v].data), det_first, PAT_W - 1);
            if (vecs[v].data == 8'h00)
                check_int("loopback_hits_00", det_hits, 1);
        end
        scramble = 1'b0;

        // back-to-back frames with start held high
        hold_len = FLEN + 1;
        push_frame(8'h00);
        push_idle(1);
        push_frame(8'h00);
        push_idle(3);
        det_reset();
        start_frame(8'h00);
        drain("back_to_back", -1, -1);
        check_int("loopback_hits_two_frames", det_hits, 2);
        hold_len = 0;
        start    = 1'b0;

        // asynchronous reset in the middle of DATA
        push_frame(8'hA5);
        start_frame(8'hA5);
        drain("pre_reset_frame", -1, PAT_W + 2);
        #2 rst = 1'b0;
        #1 check("async_reset_no_edge", observe(), mk(ST_IDLE, 1'b1, 1'b0, 1'b1));
        exp_q.delete();
        @(posedge clk);
        #1 check("reset_held", observe(), mk(ST_IDLE, 1'b1, 1'b0, 1'b1));
        rst = 1'b1;
        push_idle(FLEN + 2);
        drain("after_abort", -1, -1);

        // normal frame after the aborted one
        det_reset();
        push_frame(8'h5A);
        push_idle(2);
        start_frame(8'h5A);
        drain("frame_after_reset", -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
